// File: rtl/slot_fifo_if.sv
// rtl/slot_fifo_if.sv - producer/consumer signal bundle for slot_fifo
interface slot_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_write;
  logic                  write;
  logic                  full;
  logic                  almost_full;
  logic [DATA_WIDTH-1:0] data_read;
  logic                  next_read;
  logic                  empty;

  // master drives push/pop requests; slave is the FIFO itself
  modport master (
    output data_write, write, next_read,
    input  full, almost_full, data_read, empty
  );

  modport slave (
    input  data_write, write, next_read,
    output full, almost_full, data_read, empty
  );
endinterface

// File: rtl/slot_fifo.sv
// rtl/slot_fifo.sv - first-word-fall-through FIFO with one slot of almost_full slack
module slot_fifo #(
  parameter int NUM_SLOTS     = 4,
  parameter int LOG_NUM_SLOTS = 2,
  parameter int DATA_WIDTH    = 8
) (
  input logic         clk,
  input logic         rst,
  slot_fifo_if.slave  bus
);
  localparam int unsigned DEPTH_I = NUM_SLOTS;
  localparam int unsigned LAST_I  = NUM_SLOTS - 1;
  localparam logic [LOG_NUM_SLOTS:0]   DEPTH    = DEPTH_I[LOG_NUM_SLOTS:0];
  localparam logic [LOG_NUM_SLOTS:0]   AF_LEVEL = LAST_I[LOG_NUM_SLOTS:0];
  localparam logic [LOG_NUM_SLOTS-1:0] LAST     = LAST_I[LOG_NUM_SLOTS-1:0];

  logic [DATA_WIDTH-1:0]    mem_q [NUM_SLOTS];
  logic [LOG_NUM_SLOTS-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_NUM_SLOTS-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_NUM_SLOTS:0]   count_q, count_d;
  logic                     push, pop;

  // acceptance uses registered occupancy only, so full+both pops and empty+both pushes
  assign push = bus.write     && (count_q != DEPTH);
  assign pop  = bus.next_read && (count_q != '0);

  assign bus.full        = (count_q == DEPTH);
  assign bus.almost_full = (count_q >= AF_LEVEL);
  assign bus.empty       = (count_q == '0);
  assign bus.data_read   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage is cleared on reset so data_read reads zero straight out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= bus.data_write;
    end
  end
endmodule

// File: tb/tb_slot_fifo.sv
// tb/tb_slot_fifo.sv - randomized and directed scoreboard bench for slot_fifo
module tb_slot_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       w   = 1'b0;
  logic       r   = 1'b0;
  logic [7:0] d   = 8'h00;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] q4[$];
  logic [7:0] q3[$];
  int         pre4 = 0;
  int         pre3 = 0;
  bit         pop4 = 1'b0;
  bit         pop3 = 1'b0;

  always #5 clk = ~clk;

  slot_fifo_if #(.DATA_WIDTH(8)) bus4();
  slot_fifo_if #(.DATA_WIDTH(8)) bus3();

  assign bus4.data_write = d;
  assign bus4.write      = w;
  assign bus4.next_read  = r;
  assign bus3.data_write = d;
  assign bus3.write      = w;
  assign bus3.next_read  = r;

  slot_fifo #(.NUM_SLOTS(4), .LOG_NUM_SLOTS(2), .DATA_WIDTH(8)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  slot_fifo #(.NUM_SLOTS(3), .LOG_NUM_SLOTS(2), .DATA_WIDTH(8)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock of stimulus; the reference queues learn what the FIFO must accept
  task automatic step(input logic wv, input logic rv, input logic [7:0] dv);
    pre4 = q4.size();
    pre3 = q3.size();
    pop4 = rv && (pre4 > 0);
    pop3 = rv && (pre3 > 0);
    if (wv && pre4 < 4) q4.push_back(dv);
    if (wv && pre3 < 3) q3.push_back(dv);
    w = wv;
    r = rv;
    d = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    q4.delete();
    q3.delete();
    pre4 = 0;
    pre3 = 0;
    pop4 = 1'b0;
    pop3 = 1'b0;
  endtask

  // monitor: flags from pre-edge occupancy, popped words against queue heads
  always @(negedge clk) begin
    if (!rst) begin
      chk("n4_empty", {31'd0, bus4.empty},       {31'd0, pre4 == 0});
      chk("n4_full",  {31'd0, bus4.full},        {31'd0, pre4 == 4});
      chk("n4_afull", {31'd0, bus4.almost_full}, {31'd0, pre4 >= 3});
      chk("n3_empty", {31'd0, bus3.empty},       {31'd0, pre3 == 0});
      chk("n3_full",  {31'd0, bus3.full},        {31'd0, pre3 == 3});
      chk("n3_afull", {31'd0, bus3.almost_full}, {31'd0, pre3 >= 2});
      if (pop4) chk("n4_data", {24'd0, bus4.data_read}, {24'd0, q4.pop_front()});
      if (pop3) chk("n3_data", {24'd0, bus3.data_read}, {24'd0, q3.pop_front()});
      pop4 = 1'b0;
      pop3 = 1'b0;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_empty4"}, {31'd0, bus4.empty},       32'd1);
    chk({tag, "_full4"},  {31'd0, bus4.full},        32'd0);
    chk({tag, "_afull4"}, {31'd0, bus4.almost_full}, 32'd0);
    chk({tag, "_data4"},  {24'd0, bus4.data_read},   32'd0);
    chk({tag, "_empty3"}, {31'd0, bus3.empty},       32'd1);
    chk({tag, "_data3"},  {24'd0, bus3.data_read},   32'd0);
  endtask

  initial begin
    #2;
    chk_reset_outputs("rst0");
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // fill and drain
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    chk("fill3_afull", {31'd0, bus4.almost_full}, 32'd1);
    chk("fill3_full",  {31'd0, bus4.full},        32'd0);
    step(1'b1, 1'b0, 8'h44);
    chk("fill4_full",  {31'd0, bus4.full},        32'd1);
    step(1'b1, 1'b0, 8'h55);
    chk("drop_head",   {24'd0, bus4.data_read},   32'h11);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00);
    chk("drain_empty", {31'd0, bus4.empty},       32'd1);

    // first word fall-through
    step(1'b1, 1'b0, 8'hA5);
    chk("fwft_data",  {24'd0, bus4.data_read}, 32'hA5);
    chk("fwft_empty", {31'd0, bus4.empty},     32'd0);
    step(1'b0, 1'b1, 8'h00);

    // steady push+pop at occupancy 2
    step(1'b1, 1'b0, 8'h01);
    step(1'b1, 1'b0, 8'h02);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'(i + 3));
    chk("steady_head", {24'd0, bus4.data_read}, 32'd11);
    chk("steady_af",   {31'd0, bus4.almost_full}, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);

    // push+pop while empty: push only
    step(1'b1, 1'b1, 8'h66);
    chk("emptyboth_empty", {31'd0, bus4.empty},     32'd0);
    chk("emptyboth_data",  {24'd0, bus4.data_read}, 32'h66);
    step(1'b0, 1'b1, 8'h00);

    // push+pop while full: pop only
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    step(1'b1, 1'b1, 8'h77);
    chk("fullboth_full", {31'd0, bus4.full},        32'd0);
    chk("fullboth_af",   {31'd0, bus4.almost_full}, 32'd1);
    chk("fullboth_data", {24'd0, bus4.data_read},   32'hC1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00);

    // asynchronous reset mid-cycle with contents present
    step(1'b1, 1'b0, 8'h9C);
    step(1'b1, 1'b0, 8'h9D);
    w = 1'b0;
    r = 1'b0;
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    chk_reset_outputs("rst1");
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // underflow attempts then a push
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 8'h5A);
    chk("uflow_data",  {24'd0, bus4.data_read},   32'h5A);
    chk("uflow_empty", {31'd0, bus4.empty},       32'd0);
    chk("uflow_af",    {31'd0, bus4.almost_full}, 32'd0);
    chk("uflow_data3", {24'd0, bus3.data_read},   32'h5A);
    step(1'b0, 1'b1, 8'h00);

    // pointer wrap: 3 x depth push/pop pairs
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 8'(8'h20 + i));
      step(1'b0, 1'b1, 8'h00);
    end

    // randomized traffic, producer sometimes ignores flags
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50, 8'($urandom));
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("final_empty4", {31'd0, bus4.empty}, 32'd1);
    chk("final_empty3", {31'd0, bus3.empty}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
